uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set receive-byte FIFO entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 8, SHALL set width of both error counters.
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx_data  input  8  SHALL carry the received byte, valid only when rx_done_tick is high.
REQ-006 rx_done_tick  input  1  SHALL be a one-clock strobe marking a new rx_data byte.
REQ-007 report_busy  input  1  SHALL be high while the downstream transmit sequencer is sending a report.
REQ-008 go  output  1  SHALL be a one-clock start-timer pulse.
REQ-009 stop  output  1  SHALL be a one-clock stop-timer pulse.
REQ-010 clr  output  1  SHALL be a one-clock clear-timer pulse.
REQ-011 report  output  1  SHALL be a one-clock request-report pulse.
REQ-012 fifo_full  output  1  SHALL be high while the FIFO holds FIFO_DEPTH bytes.
REQ-013 overflow_cnt  output  CNT_W  SHALL count bytes dropped due to a full FIFO.
REQ-014 bad_cmd_cnt  output  CNT_W  SHALL count unrecognised command bytes.

Function
REQ-015 On rx_done_tick with FIFO not full at start of cycle, rx_data SHALL be written to the FIFO tail.
REQ-016 On rx_done_tick with FIFO full, the byte SHALL be dropped and overflow_cnt incremented, saturating at all-ones; a same-cycle pop SHALL NOT rescue it.
REQ-017 FSM states: IDLE, POP, DECODE, WAIT_TX.
REQ-018 IDLE -> POP when FIFO not empty; POP SHALL read head byte into a command register and advance read pointer.
REQ-019 POP -> DECODE unconditionally; DECODE classifies the command register.
REQ-020 Decode SHALL be case-insensitive: 'G'/'g' (0x47/0x67) -> go; 'S'/'s' (0x53/0x73) -> stop; 'C'/'c' (0x43/0x63) -> clr; 'R'/'r' (0x52/0x72) -> report.
REQ-021 CR (0x0D), LF (0x0A) and space (0x20) SHALL be ignored without counting.
REQ-022 Any other byte SHALL increment bad_cmd_cnt, saturating at all-ones, with no pulse.
REQ-023 From DECODE: go/stop/clr/ignored/bad -> IDLE; report with report_busy low -> IDLE; report with report_busy high -> WAIT_TX.
REQ-024 WAIT_TX SHALL hold, popping nothing, until report_busy is sampled low, then -> IDLE.
REQ-025 All pulse outputs SHALL be registered and high for exactly one clock, issued on the edge leaving DECODE (or WAIT_TX for a deferred report).
REQ-026 Latency: byte strobed at edge k into an empty FIFO with FSM IDLE SHALL produce its pulse high during the cycle after edge k+3.
REQ-027 At most one of go/stop/clr/report SHALL be high in any cycle.
REQ-028 Simultaneous push and pop with FIFO neither full nor empty SHALL both take effect; occupancy unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.
REQ-030 Commands SHALL be executed strictly in arrival order.

Reset
REQ-031 Reset low SHALL asynchronously force: FSM IDLE, FIFO empty, pointers 0, command register 0x00, both counters 0, go/stop/clr/report 0, fifo_full 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered bytes and any pending WAIT_TX report; no pulse SHALL follow deassertion without new input.

Structure
REQ-033 ASCII command constants and the FSM state encoding SHALL reside in shared package uart_stopwatch_pkg.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, with push/pop/full/empty ports.

Verification
REQ-035 Reset, send 'g' -> single go pulse 4 cycles after strobe; all other outputs 0.
REQ-036 Send 'S','c','R' back-to-back, report_busy low -> stop, clr, report pulses in that order, one clock each, none coincident.
REQ-037 Hold report_busy high, send 'r' -> no report pulse; drop report_busy -> report pulse next cycle; later 'g' not pulsed before it.
REQ-038 Block FSM in WAIT_TX, strobe 6 bytes with FIFO_DEPTH=4 -> fifo_full high, overflow_cnt=2, first 4 bytes executed after release.
REQ-039 Send 'x', 0x0D, 0x0A, 'Q' -> bad_cmd_cnt=2, no pulses; force 255+ bad bytes -> bad_cmd_cnt holds 0xFF.
REQ-040 Reset asserted with 3 bytes queued -> after deassertion no pulses, counters 0, fifo_full 0.

Source files
------------

// File: rtl/uart_stopwatch_pkg.sv
// Shared constants for the UART stopwatch command path: ASCII command bytes,
// decoder FSM state encoding and the byte classifier.
package uart_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_DECODE  = 2'd2,
    ST_WAIT_TX = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CMD_GO,
    CMD_STOP,
    CMD_CLR,
    CMD_REPORT,
    CMD_IGNORE,
    CMD_BAD
  } cmd_e;

  localparam logic [7:0] ASCII_G_UP = 8'h47;
  localparam logic [7:0] ASCII_G_LO = 8'h67;
  localparam logic [7:0] ASCII_S_UP = 8'h53;
  localparam logic [7:0] ASCII_S_LO = 8'h73;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;

  function automatic cmd_e classify(input logic [7:0] b);
    cmd_e c;
    case (b)
      ASCII_G_UP, ASCII_G_LO:     c = CMD_GO;
      ASCII_S_UP, ASCII_S_LO:     c = CMD_STOP;
      ASCII_C_UP, ASCII_C_LO:     c = CMD_CLR;
      ASCII_R_UP, ASCII_R_LO:     c = CMD_REPORT;
      ASCII_CR, ASCII_LF, ASCII_SP: c = CMD_IGNORE;
      default:                    c = CMD_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / pulse-out bundle between the UART receiver side and the command decoder.
interface uart_cmd_decoder_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_done_tick;
  logic             report_busy;
  logic             go;
  logic             stop;
  logic             clr;
  logic             report;
  logic             fifo_full;
  logic [CNT_W-1:0] overflow_cnt;
  logic [CNT_W-1:0] bad_cmd_cnt;

  modport master (
    output rx_data, rx_done_tick, report_busy,
    input  go, stop, clr, report, fifo_full, overflow_cnt, bad_cmd_cnt
  );

  modport slave (
    input  rx_data, rx_done_tick, report_busy,
    output go, stop, clr, report, fifo_full, overflow_cnt, bad_cmd_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// Buffers received UART bytes and turns command letters into one-clock
// timer control pulses, counting overflowed and unrecognised bytes.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | waiting for a buffered byte
//   ST_POP     | head byte -> cmd_q, read pointer advanced
//   ST_DECODE  | classify cmd_q, issue pulse / count / defer report
//   ST_WAIT_TX | report pending until the transmit sequencer goes idle
module uart_cmd_decoder
  import uart_stopwatch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  uart_cmd_decoder_if.slave bus
);
  state_e           state_q;
  logic [7:0]       cmd_q;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             go_q, stop_q, clr_q, report_q;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q;

  // full is taken from the registered pointers, so a pop this cycle never frees room.
  assign push = bus.rx_done_tick && !full;
  assign pop  = (state_q == ST_POP) && !empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (bus.rx_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (bus.rx_done_tick && full && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'h00;
      go_q      <= 1'b0;
      stop_q    <= 1'b0;
      clr_q     <= 1'b0;
      report_q  <= 1'b0;
      bad_cnt_q <= '0;
    end else begin
      go_q     <= 1'b0;
      stop_q   <= 1'b0;
      clr_q    <= 1'b0;
      report_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!empty) state_q <= ST_POP;
        end
        ST_POP: begin
          cmd_q   <= head;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          state_q <= ST_IDLE;
          case (classify(cmd_q))
            CMD_GO:   go_q   <= 1'b1;
            CMD_STOP: stop_q <= 1'b1;
            CMD_CLR:  clr_q  <= 1'b1;
            CMD_REPORT: begin
              if (bus.report_busy) state_q  <= ST_WAIT_TX;
              else                 report_q <= 1'b1;
            end
            CMD_BAD: begin
              if (bad_cnt_q != '1) bad_cnt_q <= bad_cnt_q + 1'b1;
            end
            default: ;
          endcase
        end
        ST_WAIT_TX: begin
          if (!bus.report_busy) begin
            report_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.go           = go_q;
  assign bus.stop         = stop_q;
  assign bus.clr          = clr_q;
  assign bus.report       = report_q;
  assign bus.fifo_full    = full;
  assign bus.overflow_cnt = ovf_cnt_q;
  assign bus.bad_cmd_cnt  = bad_cnt_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed corner cases plus a
// randomized byte stream scored against an ordered command model.
module tb_uart_cmd_decoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_decoder_if #(.CNT_W(CNT_W)) bus();

  uart_cmd_decoder #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int k, e, exp_bad;
  byte unsigned obs_code[$];
  int           obs_cyc[$];
  byte unsigned exp_code[$];
  byte unsigned cmds[8] = '{8'h47, 8'h53, 8'h43, 8'h52, 8'h67, 8'h73, 8'h63, 8'h72};
  byte unsigned ign[3]  = '{8'h0D, 8'h0A, 8'h20};
  byte unsigned blk[6]  = '{8'h67, 8'h73, 8'h63, 8'h47, 8'h53, 8'h43};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: records every pulse with the cycle it was seen in.
  always @(negedge clk) begin
    int n;
    if (reset) begin
      n = int'(bus.go) + int'(bus.stop) + int'(bus.clr) + int'(bus.report);
      if (n != 0) check("onehot", n, 1);
      if (bus.go)     begin obs_code.push_back(8'h47); obs_cyc.push_back(cyc); end
      if (bus.stop)   begin obs_code.push_back(8'h53); obs_cyc.push_back(cyc); end
      if (bus.clr)    begin obs_code.push_back(8'h43); obs_cyc.push_back(cyc); end
      if (bus.report) begin obs_code.push_back(8'h52); obs_cyc.push_back(cyc); end
    end
  end

  // Reference: upper-case letter code for a command, 0 ignored, -1 bad.
  function automatic int model_cmd(input byte unsigned b);
    int u;
    u = (b >= 8'h61 && b <= 8'h7A) ? int'(b) - 32 : int'(b);
    if (u == 8'h47 || u == 8'h53 || u == 8'h43 || u == 8'h52) return u;
    if (b == 8'h0D || b == 8'h0A || b == 8'h20) return 0;
    return -1;
  endfunction

  task automatic model_feed(input byte unsigned b);
    int r;
    r = model_cmd(b);
    if (r > 0) exp_code.push_back(byte'(r));
    else if (r < 0 && exp_bad < 255) exp_bad++;
  endtask

  task automatic send(input byte unsigned b);
    @(posedge clk); #1;
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(posedge clk); #1;
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_go"},     bus.go, 0);
    check({tag, "_stop"},   bus.stop, 0);
    check({tag, "_clr"},    bus.clr, 0);
    check({tag, "_report"}, bus.report, 0);
    check({tag, "_full"},   bus.fifo_full, 0);
    check({tag, "_ovf"},    bus.overflow_cnt, 0);
    check({tag, "_bad"},    bus.bad_cmd_cnt, 0);
  endtask

  task automatic clear_q();
    obs_code.delete();
    obs_cyc.delete();
    exp_code.delete();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check_zero(tag);
    idle(2);
    reset = 1'b1;
    exp_bad = 0;
    clear_q();
  endtask

  task automatic compare_pulses(input string tag);
    int n;
    check({tag, "_npulse"}, obs_code.size(), exp_code.size());
    n = (obs_code.size() < exp_code.size()) ? obs_code.size() : exp_code.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_cmd%0d", tag, i), obs_code[i], exp_code[i]);
    clear_q();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.report_busy  = 1'b0;
    exp_bad          = 0;
    #23;
    check_zero("rst_hold");
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    check_zero("rst_after");

    // Single 'g': pulse during the cycle after strobe edge + 3.
    send(8'h67);
    k = cyc;
    idle(8);
    check("g_npulse", obs_code.size(), 1);
    if (obs_code.size() >= 1) begin
      check("g_code", obs_code[0], 8'h47);
      check("g_latency", obs_cyc[0], k + 3);
    end
    clear_q();

    // Back-to-back S, c, R.
    send(8'h53); model_feed(8'h53);
    send(8'h63); model_feed(8'h63);
    send(8'h52); model_feed(8'h52);
    idle(15);
    compare_pulses("seq");

    // Deferred report while transmitter busy; later 'g' must wait behind it.
    bus.report_busy = 1'b1;
    send(8'h72);
    send(8'h67);
    idle(20);
    check("busy_hold", obs_code.size(), 0);
    @(posedge clk); #1;
    bus.report_busy = 1'b0;
    e = cyc;
    idle(10);
    check("defer_npulse", obs_code.size(), 2);
    if (obs_code.size() == 2) begin
      check("defer_code", obs_code[0], 8'h52);
      check("defer_lat", obs_cyc[0], e + 1);
      check("defer_then_g", obs_code[1], 8'h47);
    end
    clear_q();

    // Overflow while blocked in WAIT_TX.
    do_reset("rst_ovf");
    bus.report_busy = 1'b1;
    send(8'h72);
    idle(5);
    for (int i = 0; i < 6; i++) send(blk[i]);
    check("ovf_full", bus.fifo_full, 1);
    check("ovf_cnt", bus.overflow_cnt, 6 - DEPTH);
    exp_code.push_back(8'h52);
    for (int i = 0; i < DEPTH; i++) model_feed(blk[i]);
    bus.report_busy = 1'b0;
    idle(30);
    compare_pulses("ovf");
    check("ovf_full_drained", bus.fifo_full, 0);
    check("ovf_cnt_kept", bus.overflow_cnt, 6 - DEPTH);

    // Ignored and bad bytes, then bad counter saturation.
    do_reset("rst_bad");
    send(8'h78); model_feed(8'h78); idle(2);
    send(8'h0D); model_feed(8'h0D); idle(2);
    send(8'h0A); model_feed(8'h0A); idle(2);
    send(8'h51); model_feed(8'h51);
    idle(10);
    check("bad_two", bus.bad_cmd_cnt, 2);
    compare_pulses("bad_nopulse");
    for (int i = 0; i < 258; i++) begin
      byte unsigned b;
      do b = byte'($urandom_range(0, 255)); while (model_cmd(b) != -1);
      send(b);
      model_feed(b);
      idle(1);
      if (i == 252) begin
        idle(6);
        check("bad_at_max", bus.bad_cmd_cnt, 255);
      end
    end
    idle(10);
    check("bad_sat", bus.bad_cmd_cnt, 255);
    check("bad_model", bus.bad_cmd_cnt, exp_bad);
    check("bad_ovf0", bus.overflow_cnt, 0);
    compare_pulses("bad_sat_nopulse");

    // Reset with bytes queued and a report pending.
    do_reset("rst_mid0");
    send(8'h78);
    idle(5);
    bus.report_busy = 1'b1;
    send(8'h72);
    idle(5);
    for (int i = 0; i < 5; i++) send(blk[i]);
    check("mid_full", bus.fifo_full, 1);
    check("mid_ovf", bus.overflow_cnt, 5 - DEPTH);
    check("mid_bad", bus.bad_cmd_cnt, 1);
    bus.report_busy = 1'b0;
    do_reset("rst_mid");
    idle(30);
    check("mid_npulse", obs_code.size(), 0);
    check_zero("mid_after");
    clear_q();

    // Randomized stream, spaced so the FIFO never overflows.
    do_reset("rst_rand");
    for (int i = 0; i < 200; i++) begin
      byte unsigned b;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      b = cmds[$urandom_range(0, 7)];
      else if (sel < 7) b = ign[$urandom_range(0, 2)];
      else              b = byte'($urandom_range(0, 255));
      send(b);
      model_feed(b);
      idle($urandom_range(1, 3));
    end
    idle(20);
    compare_pulses("rand");
    check("rand_bad", bus.bad_cmd_cnt, exp_bad);
    check("rand_ovf", bus.overflow_cnt, 0);
    check("rand_full", bus.fifo_full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
